axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_arb_pkg.sv | 18 +
 rtl/axis_byte_reg.sv | 50 +++++
 rtl/axis_packet_arbiter.sv | 136 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the two-port AXI-Stream packet arbiter.
package axis_arb_pkg;

   localparam int unsigned AXIS_BYTES = 1;
   localparam int unsigned DATA_W     = 8 * AXIS_BYTES;

   typedef enum logic {StIdle, StLocked} arb_state_e;

   typedef logic port_idx_t;

   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

   function automatic logic [1:0] port_onehot(input port_idx_t idx);
      return (idx == PORT1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/axis_byte_reg.sv
// One-deep register slice holding a single data byte plus tlast.
module axis_byte_reg
   import axis_arb_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   // Payload only moves on load, so it stays put while the sink stalls.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Two-port AXI-Stream packet arbiter: round-robin grant locked for a whole packet,
// with an optional idle timeout that forces release of a stalled source.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              s0_axis_tvalid,
   output logic              s0_axis_tready,
   input  logic              s0_axis_tlast,
   input  logic [DATA_W-1:0] s0_axis_tdata,
   input  logic              s1_axis_tvalid,
   output logic              s1_axis_tready,
   input  logic              s1_axis_tlast,
   input  logic [DATA_W-1:0] s1_axis_tdata,
   input  logic              s1_enable,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [1:0]        grant,
   output logic              timeout_pulse,
   output logic              timeout_sticky
);

   localparam int unsigned     CntW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);

   arb_state_e      state_q, state_d;
   port_idx_t       gnt_q, gnt_d;
   port_idx_t       last_q, last_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pulse_q, pulse_d;
   logic            sticky_q, sticky_d;

   logic              locked;
   logic              out_free;
   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;
   logic              accept;
   logic              idle_cyc;
   logic              req0;
   logic              req1;

   assign locked    = (state_q == StLocked);
   assign out_free  = !m_axis_tvalid || m_axis_tready;
   assign sel_valid = (gnt_q == PORT1) ? s1_axis_tvalid : s0_axis_tvalid;
   assign sel_last  = (gnt_q == PORT1) ? s1_axis_tlast  : s0_axis_tlast;
   assign sel_data  = (gnt_q == PORT1) ? s1_axis_tdata  : s0_axis_tdata;

   assign s0_axis_tready = locked && (gnt_q == PORT0) && out_free;
   assign s1_axis_tready = locked && (gnt_q == PORT1) && out_free;
   assign accept         = locked && out_free && sel_valid;
   // A full, stalled output stage is backpressure, not source idleness.
   assign idle_cyc       = locked && out_free && !sel_valid;

   assign req0 = s0_axis_tvalid;
   assign req1 = s1_axis_tvalid && s1_enable;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      sticky_d = sticky_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d = StLocked;
               cnt_d   = '0;
               gnt_d   = (req0 && req1) ? ~last_q : port_idx_t'(req1);
            end
         end
         StLocked: begin
            if (accept) begin
               cnt_d = '0;
               if (sel_last) begin
                  state_d = StIdle;
                  last_d  = gnt_q;
               end
            end else if (TimeoutEn && idle_cyc) begin
               if (cnt_q + CntOne == CntLimit) begin
                  state_d  = StIdle;
                  last_d   = gnt_q;
                  cnt_d    = '0;
                  pulse_d  = 1'b1;
                  sticky_d = 1'b1;
               end else if (cnt_q != CntLimit) begin
                  cnt_d = cnt_q + CntOne;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= StIdle;
         gnt_q    <= PORT0;
         last_q   <= PORT1;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
      end
   end

   assign grant          = locked ? port_onehot(gnt_q) : 2'b00;
   assign timeout_pulse  = pulse_q;
   assign timeout_sticky = sticky_q;

   axis_byte_reg u_out_reg (
      .clk_i   (clk),
      .rst_ni  (aresetn),
      .load_i  (accept),
      .data_i  (sel_data),
      .last_i  (sel_last),
      .ready_i (m_axis_tready),
      .valid_o (m_axis_tvalid),
      .data_o  (m_axis_tdata),
      .last_o  (m_axis_tlast)
   );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed scenarios plus a randomized
// alternating-packet run checked against an interleaved expected byte stream.
module tb_axis_packet_arbiter;

   typedef struct packed {
      logic [5:0] gap;
      logic       last;
      logic [7:0] data;
   } beat_t;

   typedef struct {
      int         cyc;
      int         port;
      logic [7:0] data;
      logic       last;
      logic [1:0] grant;
   } acc_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       last;
   } out_t;

   localparam int RrPort [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   localparam int RrData [8] = '{'h10, 'h11, 'h20, 'h21, 'h12, 'h13, 'h22, 'h23};

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic [1:0] s_valid;
   logic [1:0] s_last;
   logic [7:0] s_data [2];
   logic       s0_rdy, s1_rdy;
   logic [1:0] s_ready;
   logic       s1_en;
   logic       m_ready;
   logic       m_valid, m_last;
   logic [7:0] m_data;
   logic [1:0] grant;
   logic       t_pulse, t_sticky;
   logic       nt_s0_rdy, nt_s1_rdy, nt_m_valid, nt_m_last, nt_pulse, nt_sticky;
   logic [7:0] nt_m_data;
   logic [1:0] nt_grant;
   logic       rand_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   beat_t tx0[$];
   beat_t tx1[$];
   acc_t  acc[$];
   out_t  rx[$];
   int    pulse_cyc[$];
   logic [1:0] armed;
   logic [1:0] hs;
   int         gap_cnt [2];

   assign s_ready = {s1_rdy, s0_rdy};

   always #5 clk = ~clk;

   axis_packet_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .s0_axis_tvalid (s_valid[0]),
      .s0_axis_tready (s0_rdy),
      .s0_axis_tlast  (s_last[0]),
      .s0_axis_tdata  (s_data[0]),
      .s1_axis_tvalid (s_valid[1]),
      .s1_axis_tready (s1_rdy),
      .s1_axis_tlast  (s_last[1]),
      .s1_axis_tdata  (s_data[1]),
      .s1_enable      (s1_en),
      .m_axis_tvalid  (m_valid),
      .m_axis_tready  (m_ready),
      .m_axis_tlast   (m_last),
      .m_axis_tdata   (m_data),
      .grant          (grant),
      .timeout_pulse  (t_pulse),
      .timeout_sticky (t_sticky)
   );

   // Same stimulus, timeout disabled.
   axis_packet_arbiter #(.TIMEOUT_CYCLES(0)) dut_nt (
      .clk            (clk),
      .aresetn        (aresetn),
      .s0_axis_tvalid (s_valid[0]),
      .s0_axis_tready (nt_s0_rdy),
      .s0_axis_tlast  (s_last[0]),
      .s0_axis_tdata  (s_data[0]),
      .s1_axis_tvalid (s_valid[1]),
      .s1_axis_tready (nt_s1_rdy),
      .s1_axis_tlast  (s_last[1]),
      .s1_axis_tdata  (s_data[1]),
      .s1_enable      (s1_en),
      .m_axis_tvalid  (nt_m_valid),
      .m_axis_tready  (m_ready),
      .m_axis_tlast   (nt_m_last),
      .m_axis_tdata   (nt_m_data),
      .grant          (nt_grant),
      .timeout_pulse  (nt_pulse),
      .timeout_sticky (nt_sticky)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int qsize(input int p);
      return (p == 0) ? tx0.size() : tx1.size();
   endfunction

   function automatic beat_t qfront(input int p);
      return (p == 0) ? tx0[0] : tx1[0];
   endfunction

   function automatic void qpop(input int p);
      if (p == 0) void'(tx0.pop_front());
      else        void'(tx1.pop_front());
   endfunction

   task automatic push(input int p, input logic [7:0] d, input logic l, input int gap);
      beat_t b;
      b.data = d;
      b.last = l;
      b.gap  = 6'(gap);
      if (p == 0) tx0.push_back(b);
      else        tx1.push_back(b);
   endtask

   // Source drivers: one beat queue per port, optional gap before each beat.
   initial begin
      beat_t f;
      s_valid = '0;
      s_last  = '0;
      s_data[0] = '0;
      s_data[1] = '0;
      armed = '0;
      hs = '0;
      gap_cnt[0] = 0;
      gap_cnt[1] = 0;
      forever begin
         @(negedge clk);
         hs = s_valid & s_ready;
         @(posedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
               qpop(p);
               armed[p] = 1'b0;
            end
            if (qsize(p) != 0) begin
               f = qfront(p);
               if (!armed[p]) begin
                  gap_cnt[p] = int'(f.gap);
                  armed[p]   = 1'b1;
               end
               if (gap_cnt[p] != 0) begin
                  gap_cnt[p]--;
                  s_valid[p] = 1'b0;
               end else begin
                  s_valid[p] = 1'b1;
                  s_data[p]  = f.data;
                  s_last[p]  = f.last;
               end
            end else begin
               s_valid[p] = 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: log source acceptances, output handshakes and timeout pulses.
   initial forever begin
      acc_t a;
      out_t o;
      @(negedge clk);
      if (aresetn) begin
         for (int p = 0; p < 2; p++) begin
            if (s_valid[p] && s_ready[p]) begin
               a.cyc   = cyc;
               a.port  = p;
               a.data  = s_data[p];
               a.last  = s_last[p];
               a.grant = grant;
               acc.push_back(a);
            end
         end
         if (m_valid && m_ready) begin
            o.cyc  = cyc;
            o.data = m_data;
            o.last = m_last;
            rx.push_back(o);
         end
         if (t_pulse) pulse_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic assert_reset();
      @(posedge clk);
      #3;
      aresetn = 1'b0;
      tx0.delete();
      tx1.delete();
      s_valid = '0;
      s_last  = '0;
      armed   = '0;
      hs      = '0;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #3;
      acc.delete();
      rx.delete();
      pulse_cyc.delete();
      aresetn = 1'b1;
   endtask

   task automatic do_reset();
      assert_reset();
      release_reset();
   endtask

   task automatic wait_acc(input int n, input int budget, input string tag);
      int k = 0;
      while (acc.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, 32'(acc.size() >= n), 1);
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int k = 0;
      while (rx.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, 32'(rx.size() >= n), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".m_tvalid"}, 32'(m_valid), 0);
      check({tag, ".m_tdata"},  32'(m_data), 0);
      check({tag, ".m_tlast"},  32'(m_last), 0);
      check({tag, ".s0_ready"}, 32'(s0_rdy), 0);
      check({tag, ".s1_ready"}, 32'(s1_rdy), 0);
      check({tag, ".grant"},    32'(grant), 0);
      check({tag, ".pulse"},    32'(t_pulse), 0);
      check({tag, ".sticky"},   32'(t_sticky), 0);
   endtask

   initial begin
      logic [8:0] exp_q[$];
      int a0;
      int changes;
      int pulses;
      int len;
      int k;
      m_ready = 1'b1;
      s1_en   = 1'b1;
      aresetn = 1'b0;
      #2;
      check_idle_outputs("reset");

      // Single-port packet 01,02,03.
      release_reset();
      push(0, 8'h01, 1'b0, 0);
      push(0, 8'h02, 1'b0, 0);
      push(0, 8'h03, 1'b1, 0);
      wait_rx(3, 40, "single.wait");
      if (rx.size() >= 3 && acc.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("single.data", 32'(rx[i].data), 32'(i + 1));
            check("single.last", 32'(rx[i].last), 32'(i == 2));
            check("single.latency", 32'(rx[i].cyc - acc[i].cyc), 1);
            check("single.grant", 32'(acc[i].grant), 1);
         end
      end
      repeat (2) @(negedge clk);
      check("single.grant_after", 32'(grant), 0);

      // Round robin from reset: both ports hold two 2-byte packets.
      do_reset();
      push(0, 8'h10, 1'b0, 0); push(0, 8'h11, 1'b1, 0);
      push(0, 8'h12, 1'b0, 0); push(0, 8'h13, 1'b1, 0);
      push(1, 8'h20, 1'b0, 0); push(1, 8'h21, 1'b1, 0);
      push(1, 8'h22, 1'b0, 0); push(1, 8'h23, 1'b1, 0);
      wait_acc(8, 60, "rr.wait");
      wait_rx(8, 10, "rr.wait_out");
      if (acc.size() >= 8 && rx.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            check("rr.port", 32'(acc[i].port), 32'(RrPort[i]));
            check("rr.out_data", 32'(rx[i].data), 32'(RrData[i]));
            if (i > 0)
               check("rr.spacing", 32'(acc[i].cyc - acc[i-1].cyc), (i % 2 == 0) ? 2 : 1);
         end
      end

      // s1_enable gating.
      do_reset();
      s1_en = 1'b0;
      push(1, 8'h30, 1'b0, 0);
      push(1, 8'h31, 1'b0, 0);
      push(1, 8'h32, 1'b1, 0);
      repeat (6) @(negedge clk);
      check("gate.grant_off", 32'(grant), 0);
      check("gate.no_accept", 32'(acc.size()), 0);
      @(posedge clk);
      #1;
      s1_en = 1'b1;
      @(negedge clk);
      check("gate.grant_same_cycle", 32'(grant), 0);
      @(negedge clk);
      check("gate.grant_next_edge", 32'(grant), 2);
      @(posedge clk);
      #1;
      s1_en = 1'b0;
      wait_rx(3, 40, "gate.wait");
      if (rx.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("gate.data", 32'(rx[i].data), 32'('h30 + i));
            check("gate.last", 32'(rx[i].last), 32'(i == 2));
         end
      end
      s1_en = 1'b1;

      // Backpressure for 50 cycles while the source is also idle for 40 of them.
      do_reset();
      push(0, 8'h40, 1'b0, 0);
      push(0, 8'h41, 1'b0, 40);
      push(0, 8'h42, 1'b0, 0);
      push(0, 8'h43, 1'b1, 0);
      wait_acc(1, 20, "bp.wait");
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      changes = 0;
      pulses  = 0;
      repeat (50) begin
         @(negedge clk);
         if (m_data !== 8'h40 || m_valid !== 1'b1) changes++;
         if (t_pulse) pulses++;
      end
      check("bp.hold", 32'(changes), 0);
      check("bp.pulse", 32'(pulses), 0);
      check("bp.grant", 32'(grant), 1);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_rx(4, 40, "bp.wait_out");
      if (rx.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("bp.data", 32'(rx[i].data), 32'('h40 + i));
      end
      check("bp.sticky", 32'(t_sticky), 0);

      // Timeout: s1 sends one byte without tlast, then s0 waits behind it.
      do_reset();
      push(1, 8'h50, 1'b0, 0);
      wait_acc(1, 20, "to.wait_s1");
      a0 = (acc.size() > 0) ? acc[0].cyc : 0;
      push(0, 8'h60, 1'b0, 0);
      push(0, 8'h61, 1'b1, 0);
      k = 0;
      while (pulse_cyc.size() == 0 && k < 40) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("to.pulse_seen", 32'(pulse_cyc.size()), 1);
      if (pulse_cyc.size() > 0) check("to.pulse_delay", 32'(pulse_cyc[0] - a0), 17);
      wait_acc(3, 40, "to.wait_s0");
      if (acc.size() >= 3) begin
         check("to.s0_port", 32'(acc[1].port), 0);
         check("to.s0_data", 32'(acc[1].data), 'h60);
         check("to.s0_start", 32'(acc[1].cyc - a0), 18);
         check("to.s0_grant", 32'(acc[2].grant), 1);
      end
      wait_rx(3, 10, "to.wait_out");
      if (rx.size() >= 1) begin
         check("to.held_data", 32'(rx[0].data), 'h50);
         check("to.held_last", 32'(rx[0].last), 0);
      end
      repeat (5) @(negedge clk);
      check("to.pulse_count", 32'(pulse_cyc.size()), 1);
      check("to.sticky", 32'(t_sticky), 1);
      check("to.disabled_sticky", 32'(nt_sticky), 0);
      check("to.disabled_grant", 32'(nt_grant), 2);

      // Mid-packet reset after a completed s0 packet.
      do_reset();
      check("rst.sticky_cleared", 32'(t_sticky), 0);
      push(0, 8'h68, 1'b0, 0);
      push(0, 8'h69, 1'b1, 0);
      for (int i = 0; i < 5; i++) push(0, 8'(8'h70 + i), 1'(i == 4), 0);
      wait_acc(4, 40, "rst.wait");
      assert_reset();
      #1;
      check_idle_outputs("rst.mid");
      release_reset();
      push(1, 8'h80, 1'b0, 0);
      push(1, 8'h81, 1'b1, 0);
      push(0, 8'h90, 1'b0, 0);
      push(0, 8'h91, 1'b1, 0);
      wait_acc(4, 40, "rst.wait_after");
      if (acc.size() >= 4) begin
         check("rst.first_port", 32'(acc[0].port), 0);
         check("rst.first_data", 32'(acc[0].data), 'h90);
         check("rst.second_port", 32'(acc[2].port), 1);
      end

      // Randomized: both ports always have a packet ready, so output alternates.
      do_reset();
      exp_q.delete();
      for (int n = 0; n < 10; n++) begin
         for (int p = 0; p < 2; p++) begin
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
               logic [7:0] d;
               d = 8'($urandom);
               push(p, d, 1'(b == len - 1), (b == 0) ? 0 : int'($urandom_range(0, 4)));
               exp_q.push_back({1'(b == len - 1), d});
            end
         end
      end
      rand_ready = 1'b1;
      wait_rx(exp_q.size(), 3000, "rnd.wait");
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      check("rnd.count", 32'(rx.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
         check("rnd.beat", 32'({rx[i].last, rx[i].data}), 32'(exp_q[i]));
      for (int i = 0; i < acc.size(); i++)
         check("rnd.grant", 32'(acc[i].grant), (acc[i].port == 1) ? 2 : 1);
      check("rnd.sticky", 32'(t_sticky), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
